sb_ctx_sequencer: RTL and testbench
===================================

// Module: sb_ctx_sequencer
// PURPOSE
//  Multi-context configuration controller for one switch-box tile. Holds NUM_CTX
//  pre-loaded 32-bit switch-box config words and, on request, writes the selected
//  word into the tile over its config_addr/config_data/config_en port.
//  Sits between the host config bus and the switch-box config port, so routing can
//  be time-multiplexed without the host re-sending configuration.
// PARAMETERS
//  NUM_CTX     4      number of stored contexts (2..16)
//  CTX_W       2      context index width, >= clog2(NUM_CTX)
//  SB_ADDR     32'h0  value driven on config_addr for this tile
//  SETTLE_CYC  2      idle cycles after config_en before ack (1..15)
// PORTS
//  clk         in   1      clock, all logic on posedge
//  reset       in   1      asynchronous, active-low reset
//  wr_valid    in   1      host store-write request
//  wr_ready    out  1      store-write accepted when wr_valid & wr_ready
//  wr_ctx      in   CTX_W  context slot to write
//  wr_data     in   32     config word for slot
//  sw_req      in   1      context-switch request (4-phase level)
//  sw_ctx      in   CTX_W  context to apply; held stable while sw_req=1
//  sw_ack      out  1      switch complete; high until sw_req drops
//  sw_err      out  1      valid with sw_ack: sw_ctx >= NUM_CTX, nothing written
//  config_addr out  32     to switch box; constant SB_ADDR
//  config_data out  32     to switch box; registered
//  config_en   out  1      to switch box; registered single-cycle pulse
//  active_ctx  out  CTX_W  last successfully applied context
//  busy        out  1      FSM not in IDLE
// BEHAVIOUR
//  Reset (reset=0, async): FSM=IDLE; store slots, config_data, active_ctx = 0;
//   config_en, sw_ack, sw_err, busy = 0. Applies immediately, even mid-LOAD/SETTLE;
//   an interrupted switch is abandoned and never acked.
//  FSM: IDLE -> LOAD -> SETTLE -> DONE -> IDLE.
//   IDLE: if sw_req=1, latch pend_ctx=sw_ctx; go LOAD, or DONE with sw_err=1 if
//    sw_ctx >= NUM_CTX.
//   LOAD (1 cycle): config_en=1, config_data=store[pend_ctx] on the registered outputs.
//   SETTLE: counter runs SETTLE_CYC cycles; config_en=0, config_data held.
//   On exit: active_ctx <= pend_ctx; go DONE.
//   DONE: sw_ack=1 (sw_err as latched); go IDLE when sw_req=0.
//   sw_ack and sw_err clear on that transition.
//  Latency: sw_req rising in IDLE -> config_en high 2 cycles later.
//   sw_ack high SETTLE_CYC+2 cycles after config_en rises.
//  Store writes: wr_ready = (state==IDLE) | (wr_ctx != pend_ctx).
//   Accepted write updates the slot on the same edge.
//  Write and switch to same slot in same IDLE cycle: write commits first;
//   LOAD applies the new wr_data.
//  config_data keeps the last loaded word; it never reverts to 0 except on reset.
//  sw_ctx changes while sw_req=1 are ignored (pend_ctx latched once).
// CONFIGURATION
//  SB_CTX_AUTO_EN defined: adds parameter AUTO_PERIOD (default 16) and input
//   auto_en (1b). Free-running counter counts only in IDLE with auto_en=1.
//   On reaching AUTO_PERIOD-1 with sw_req=0, it self-issues a switch to
//   (active_ctx+1) mod NUM_CTX.
//   Auto switch runs LOAD/SETTLE, then returns directly to IDLE without sw_ack.
//   Counter clears on any switch.
//   External sw_req in the same cycle wins over the auto switch.
//  Undefined: no counter, no auto_en port; switches only via sw_req.
// TESTING
//  1 Reset values: reset=0 -> config_en=0, config_data=0, active_ctx=0, busy=0,
//    wr_ready=1.
//  2 Basic switch: write slot1=32'h0000_0800, sw_req ctx1 -> one config_en pulse
//    with data 32'h800. sw_ack at +SETTLE_CYC+2 after config_en; active_ctx=1.
//  3 Same-cycle write+switch: wr ctx2=32'hC00 and sw_req ctx2 together ->
//    config_data=32'hC00, not the old value.
//  4 Blocking: during SETTLE for ctx1, write ctx1 -> wr_ready=0.
//    Write ctx3 -> accepted.
//  5 Bad index (NUM_CTX=3): sw_ctx=3 -> no config_en; sw_ack=1, sw_err=1;
//    active_ctx unchanged.
//  6 Async reset during SETTLE -> outputs at reset values before next edge;
//    no sw_ack. With SB_CTX_AUTO_EN and AUTO_PERIOD=4: ctx advances 0->1->2
//    without sw_ack.

Source files
------------

// File: rtl/sb_ctx_sequencer.sv
// sb_ctx_sequencer: holds NUM_CTX switch-box config words and replays a selected one into the tile.
// Optional feature macro SB_CTX_AUTO_EN adds a timed round-robin self-switch (AUTO_PERIOD, auto_en_i).
module sb_ctx_sequencer #(
  parameter int unsigned NUM_CTX    = 4,
  parameter int unsigned CTX_W      = 2,
  parameter logic [31:0] SB_ADDR    = 32'h0,
  parameter int unsigned SETTLE_CYC = 2
`ifdef SB_CTX_AUTO_EN
  , parameter int unsigned AUTO_PERIOD = 16
`endif
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             wr_valid_i,
  output logic             wr_ready_o,
  input  logic [CTX_W-1:0] wr_ctx_i,
  input  logic [31:0]      wr_data_i,
  input  logic             sw_req_i,
  input  logic [CTX_W-1:0] sw_ctx_i,
  output logic             sw_ack_o,
  output logic             sw_err_o,
  output logic [31:0]      config_addr_o,
  output logic [31:0]      config_data_o,
  output logic             config_en_o,
  output logic [CTX_W-1:0] active_ctx_o,
  output logic             busy_o
`ifdef SB_CTX_AUTO_EN
  , input  logic           auto_en_i
`endif
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned NSLOT  = 1 << CTX_W;
  localparam int unsigned CNT_W  = 5;
  // SETTLE spans the config_en cycle, SETTLE_CYC idle cycles and the ack register stage.
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC + 1);
  localparam logic [CTX_W-1:0] LAST_CTX    = CTX_W'(NUM_CTX - 1);
`ifdef SB_CTX_AUTO_EN
  localparam int unsigned AUTO_W = $clog2(AUTO_PERIOD + 1);
  localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_PERIOD - 1);
`endif

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_SETTLE = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [CTX_W-1:0]    pend_q, pend_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                cfg_en_q, cfg_en_d;
  logic [DATA_W-1:0]   cfg_data_q, cfg_data_d;
  logic [CTX_W-1:0]    active_q, active_d;
  logic                ack_q, ack_d;
  logic                serr_q, serr_d;
  logic                busy_q, busy_d;
  logic [DATA_W-1:0]   store_q [NSLOT];
  logic                wr_ready_c;
  logic                wr_fire_c;
  logic                sw_bad_c;
`ifdef SB_CTX_AUTO_EN
  logic                auto_q, auto_d;
  logic [AUTO_W-1:0]   acnt_q, acnt_d;
  logic [CTX_W-1:0]    next_ctx_c;
`endif

  // The slot being applied is locked against host writes until the switch retires.
  assign wr_ready_c = (state_q == S_IDLE) | (wr_ctx_i != pend_q);
  assign wr_fire_c  = wr_valid_i & wr_ready_c & (32'(wr_ctx_i) < NUM_CTX);
  assign sw_bad_c   = 32'(sw_ctx_i) >= NUM_CTX;
`ifdef SB_CTX_AUTO_EN
  assign next_ctx_c = (active_q == LAST_CTX) ? '0 : active_q + CTX_W'(1);
`endif

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    cfg_en_d   = 1'b0;
    cfg_data_d = cfg_data_q;
    active_d   = active_q;
`ifdef SB_CTX_AUTO_EN
    auto_d     = auto_q;
    acnt_d     = acnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (sw_req_i) begin
          pend_d  = sw_ctx_i;
          err_d   = sw_bad_c;
          state_d = sw_bad_c ? S_DONE : S_LOAD;
`ifdef SB_CTX_AUTO_EN
          auto_d  = 1'b0;
          acnt_d  = '0;
        end else if (auto_en_i) begin
          if (acnt_q == AUTO_LAST) begin
            pend_d  = next_ctx_c;
            err_d   = 1'b0;
            auto_d  = 1'b1;
            acnt_d  = '0;
            state_d = S_LOAD;
          end else begin
            acnt_d = acnt_q + AUTO_W'(1);
          end
`endif
        end
      end
      S_LOAD: begin
        cfg_en_d   = 1'b1;
        cfg_data_d = store_q[pend_q];
        state_d    = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d    = '0;
          active_d = pend_q;
`ifdef SB_CTX_AUTO_EN
          state_d  = auto_q ? S_IDLE : S_DONE;
`else
          state_d  = S_DONE;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        if (!sw_req_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    ack_d  = (state_d == S_DONE);
    serr_d = (state_d == S_DONE) & err_d;
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= S_IDLE;
      pend_q     <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      cfg_en_q   <= 1'b0;
      cfg_data_q <= '0;
      active_q   <= '0;
      ack_q      <= 1'b0;
      serr_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      cfg_en_q   <= cfg_en_d;
      cfg_data_q <= cfg_data_d;
      active_q   <= active_d;
      ack_q      <= ack_d;
      serr_q     <= serr_d;
      busy_q     <= busy_d;
    end
  end

`ifdef SB_CTX_AUTO_EN
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      auto_q <= 1'b0;
      acnt_q <= '0;
    end else begin
      auto_q <= auto_d;
      acnt_q <= acnt_d;
    end
  end
`endif

  // Writes to slots beyond NUM_CTX are accepted but dropped; those entries stay at zero.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      for (int unsigned i = 0; i < NSLOT; i++) begin
        store_q[i] <= '0;
      end
    end else if (wr_fire_c) begin
      store_q[wr_ctx_i] <= wr_data_i;
    end
  end

  assign wr_ready_o    = wr_ready_c;
  assign sw_ack_o      = ack_q;
  assign sw_err_o      = serr_q;
  assign config_addr_o = SB_ADDR;
  assign config_data_o = cfg_data_q;
  assign config_en_o   = cfg_en_q;
  assign active_ctx_o  = active_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_sb_ctx_sequencer.sv
// Scoreboard bench for sb_ctx_sequencer (NUM_CTX=3, SETTLE_CYC=2); exercises the
// SB_CTX_AUTO_EN round-robin path (AUTO_PERIOD=4) when that macro is defined.
module tb_sb_ctx_sequencer;

  localparam int unsigned SETTLE = 2;
  localparam logic [31:0] ADDR   = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        wr_valid;
  logic        wr_ready;
  logic [1:0]  wr_ctx;
  logic [31:0] wr_data;
  logic        sw_req;
  logic [1:0]  sw_ctx;
  logic        sw_ack;
  logic        sw_err;
  logic [31:0] config_addr;
  logic [31:0] config_data;
  logic        config_en;
  logic [1:0]  active_ctx;
  logic        busy;
`ifdef SB_CTX_AUTO_EN
  logic        auto_en;
`endif

  sb_ctx_sequencer #(
    .NUM_CTX    (3),
    .CTX_W      (2),
    .SB_ADDR    (ADDR),
    .SETTLE_CYC (SETTLE)
`ifdef SB_CTX_AUTO_EN
    , .AUTO_PERIOD (4)
`endif
  ) u_dut (
    .clk_i         (clk),
    .reset_ni      (reset_n),
    .wr_valid_i    (wr_valid),
    .wr_ready_o    (wr_ready),
    .wr_ctx_i      (wr_ctx),
    .wr_data_i     (wr_data),
    .sw_req_i      (sw_req),
    .sw_ctx_i      (sw_ctx),
    .sw_ack_o      (sw_ack),
    .sw_err_o      (sw_err),
    .config_addr_o (config_addr),
    .config_data_o (config_data),
    .config_en_o   (config_en),
    .active_ctx_o  (active_ctx),
    .busy_o        (busy)
`ifdef SB_CTX_AUTO_EN
    , .auto_en_i   (auto_en)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] data; int cyc; } cfg_exp_t;
  typedef struct { logic err; logic [1:0] act; int cyc; } ack_exp_t;

  cfg_exp_t cfg_q[$];
  ack_exp_t ack_q[$];
  cfg_exp_t ce;
  ack_exp_t ae;
  logic     prev_ack = 1'b0;
  int       n_chk = 0;
  int       n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: pops an expectation on every config_en pulse and every rising sw_ack.
  always @(negedge clk) begin
    if (reset_n) begin
      if (config_en) begin
        if (cfg_q.size() == 0) begin
          check("spurious config_en", 32'(config_en), 32'd0);
        end else begin
          ce = cfg_q.pop_front();
          check("config_data", config_data, ce.data);
          check("config_addr", config_addr, ADDR);
          if (ce.cyc >= 0) check("config_en cycle", 32'(cyc), 32'(ce.cyc));
        end
      end
      if (sw_ack && !prev_ack) begin
        if (ack_q.size() == 0) begin
          check("spurious sw_ack", 32'(sw_ack), 32'd0);
        end else begin
          ae = ack_q.pop_front();
          check("sw_err", 32'(sw_err), 32'(ae.err));
          check("active_ctx at ack", 32'(active_ctx), 32'(ae.act));
          check("sw_ack cycle", 32'(cyc), 32'(ae.cyc));
        end
      end
    end
    prev_ack <= sw_ack;
  end

  task automatic wr(input logic [1:0] ctx, input logic [31:0] d);
    wr_valid = 1'b1;
    wr_ctx   = ctx;
    wr_data  = d;
    #1 check("wr_ready idle", 32'(wr_ready), 32'd1);
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic wait_ack();
    for (int i = 0; i < 40 && !sw_ack; i++) @(negedge clk);
    if (!sw_ack) check("sw_ack timeout", 32'(sw_ack), 32'd1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && busy; i++) @(negedge clk);
    check("busy after switch", 32'(busy), 32'd0);
    check("sw_ack cleared", 32'(sw_ack), 32'd0);
    check("sw_err cleared", 32'(sw_err), 32'd0);
  endtask

  // Issues a switch, optionally with a same-cycle store write to the target slot.
  task automatic sw(input logic [1:0] ctx, input logic [31:0] d, input logic bad,
                    input logic [1:0] act, input logic with_wr, input logic [31:0] wd);
    int c0;
    c0 = cyc;
    sw_req = 1'b1;
    sw_ctx = ctx;
    if (with_wr) begin
      wr_valid = 1'b1;
      wr_ctx   = ctx;
      wr_data  = wd;
    end
    if (!bad) cfg_q.push_back('{data: d, cyc: c0 + 2});
    ack_q.push_back('{err: bad, act: act, cyc: bad ? c0 + 1 : c0 + 2 + int'(SETTLE) + 2});
    @(negedge clk);
    wr_valid = 1'b0;
    wait_ack();
    @(negedge clk);
    sw_req = 1'b0;
    wait_idle();
  endtask

  initial begin
    int c0;
    reset_n  = 1'b0;
    wr_valid = 1'b0;
    wr_ctx   = '0;
    wr_data  = '0;
    sw_req   = 1'b0;
    sw_ctx   = '0;
`ifdef SB_CTX_AUTO_EN
    auto_en  = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst config_en", 32'(config_en), 32'd0);
    check("rst config_data", config_data, 32'd0);
    check("rst active_ctx", 32'(active_ctx), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst wr_ready", 32'(wr_ready), 32'd1);
    check("rst sw_ack", 32'(sw_ack), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Basic switch, then same-cycle write+switch overriding an older slot value.
    wr(2'd1, 32'h0000_0800);
    wr(2'd2, 32'h0000_0111);
    sw(2'd1, 32'h0000_0800, 1'b0, 2'd1, 1'b0, 32'h0);
    check("active after ctx1", 32'(active_ctx), 32'd1);
    sw(2'd2, 32'h0000_0C00, 1'b0, 2'd2, 1'b1, 32'h0000_0C00);
    check("config_data held", config_data, 32'h0000_0C00);

    // Slot under switch is write-locked during SETTLE; other slots stay writable.
    c0 = cyc;
    sw_req = 1'b1;
    sw_ctx = 2'd1;
    cfg_q.push_back('{data: 32'h0000_0800, cyc: c0 + 2});
    ack_q.push_back('{err: 1'b0, act: 2'd1, cyc: c0 + 2 + int'(SETTLE) + 2});
    repeat (2) @(negedge clk);
    wr_valid = 1'b1;
    wr_ctx   = 2'd1;
    wr_data  = 32'hDEAD_BEEF;
    #1 check("wr_ready blocked", 32'(wr_ready), 32'd0);
    check("busy in settle", 32'(busy), 32'd1);
    @(negedge clk);
    wr_ctx = 2'd3;
    #1 check("wr_ready ctx3", 32'(wr_ready), 32'd1);
    wr_ctx  = 2'd0;
    wr_data = 32'h0000_0005;
    #1 check("wr_ready ctx0", 32'(wr_ready), 32'd1);
    @(negedge clk);
    wr_valid = 1'b0;
    wait_ack();
    @(negedge clk);
    sw_req = 1'b0;
    wait_idle();
    sw(2'd0, 32'h0000_0005, 1'b0, 2'd0, 1'b0, 32'h0);
    sw(2'd1, 32'h0000_0800, 1'b0, 2'd1, 1'b0, 32'h0);

    // Out-of-range context: error ack, nothing written, active unchanged.
    sw(2'd3, 32'h0, 1'b1, 2'd1, 1'b0, 32'h0);
    check("active after bad", 32'(active_ctx), 32'd1);
    check("config_data after bad", config_data, 32'h0000_0800);

    // Async reset mid-SETTLE abandons the switch.
    c0 = cyc;
    sw_req = 1'b1;
    sw_ctx = 2'd2;
    cfg_q.push_back('{data: 32'h0000_0C00, cyc: c0 + 2});
    repeat (3) @(negedge clk);
    #2;
    reset_n = 1'b0;
    sw_req  = 1'b0;
    #1;
    check("arst config_en", 32'(config_en), 32'd0);
    check("arst config_data", config_data, 32'd0);
    check("arst active_ctx", 32'(active_ctx), 32'd0);
    check("arst busy", 32'(busy), 32'd0);
    check("arst sw_ack", 32'(sw_ack), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    check("post-reset busy", 32'(busy), 32'd0);
    check("post-reset active", 32'(active_ctx), 32'd0);

`ifdef SB_CTX_AUTO_EN
    wr(2'd1, 32'h0000_0011);
    wr(2'd2, 32'h0000_0022);
    cfg_q.push_back('{data: 32'h0000_0011, cyc: -1});
    cfg_q.push_back('{data: 32'h0000_0022, cyc: -1});
    auto_en = 1'b1;
    for (int i = 0; i < 80 && active_ctx != 2'd2; i++) @(negedge clk);
    auto_en = 1'b0;
    check("auto active_ctx", 32'(active_ctx), 32'd2);
    repeat (10) @(negedge clk);
    check("auto idle", 32'(busy), 32'd0);
    check("auto no ack", 32'(sw_ack), 32'd0);
`endif

    repeat (2) @(negedge clk);
    check("cfg queue drained", 32'(cfg_q.size()), 32'd0);
    check("ack queue drained", 32'(ack_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish (%0d/%0d so far)", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

endmodule
